// File: rtl/neureka_acc_pkg.sv
// Shared drain FSM states, wide request bundle and saturating add for the accumulator buffer.
// The saturating add is used only when NEUREKA_ACC_BUF_SAT_EN is defined.
package neureka_acc_pkg;

    localparam int unsigned ACC_MAX_DW     = 64;
    localparam int unsigned ACC_MAX_WF     = 32;
    localparam int unsigned ACC_MAX_WIN_W  = 16;
    localparam int unsigned ACC_MAX_DATA_W = ACC_MAX_WF * ACC_MAX_DW;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_FLUSH,
        ACC_DRAIN
    } acc_drain_state_e;

    // Sized for the largest supported instance; narrower instances zero-extend.
    typedef struct packed {
        logic [ACC_MAX_WIN_W-1:0]  win;
        logic [ACC_MAX_WF-1:0]     mask;
        logic [ACC_MAX_DATA_W-1:0] data;
        logic                      acc;
    } acc_wide_req_t;

    // Operands arrive sign-extended from dw bits; the top result bit flags a clamp.
    function automatic logic [ACC_MAX_DW:0] acc_sat_add(
        input logic [ACC_MAX_DW-1:0] a,
        input logic [ACC_MAX_DW-1:0] b,
        input int unsigned           dw
    );
        logic signed [ACC_MAX_DW:0] sum;
        logic signed [ACC_MAX_DW:0] hi;
        logic signed [ACC_MAX_DW:0] lo;
        logic signed [ACC_MAX_DW:0] res;
        logic                       sat;
        sum = signed'({a[ACC_MAX_DW-1], a}) + signed'({b[ACC_MAX_DW-1], b});
        hi  = '0;
        for (int unsigned i = 0; i < ACC_MAX_DW; i++) begin
            hi[i] = (i + 1 < dw);
        end
        lo  = ~hi;
        sat = (sum > hi) || (sum < lo);
        res = sum;
        if (sum > hi) begin
            res = hi;
        end else if (sum < lo) begin
            res = lo;
        end
        return {sat, res[ACC_MAX_DW-1:0]};
    endfunction

endpackage

// File: rtl/neureka_acc_drain_fsm.sv
// Drain sequencer: IDLE -> (FLUSH) -> DRAIN, one beat per valid/ready handshake.
// Holds the beat counter; the payload mux lives in the buffer top.
module neureka_acc_drain_fsm
    import neureka_acc_pkg::*;
#(
    parameter  int unsigned BEATS  = 4,
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic              last_o,
    output logic [BEAT_W-1:0] beat_o,
    output logic              idle_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    acc_drain_state_e  state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              at_last;

    assign at_last = (beat_q == LAST_BEAT);
    assign valid_o = enable_i & (state_q == ACC_DRAIN);
    assign last_o  = valid_o & at_last;
    assign beat_o  = beat_q;
    assign idle_o  = (state_q == ACC_IDLE);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            ACC_IDLE: begin
                if (start_i) begin
                    state_d = flush_i ? ACC_FLUSH : ACC_DRAIN;
                    beat_d  = '0;
                end
            end
            ACC_FLUSH: state_d = ACC_DRAIN;
            ACC_DRAIN: begin
                if (ready_i) begin
                    if (at_last) begin
                        state_d = ACC_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = ACC_IDLE;
        endcase
        if (clear_i) begin
            state_d = ACC_IDLE;
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACC_IDLE;
            beat_q  <= '0;
        end else if (enable_i) begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/neureka_accumulator_buffer_stream.sv
// Strided-window accumulator buffer with pipelined wide RMW port and streaming drain.
// Define NEUREKA_ACC_BUF_SAT_EN for signed saturating accumulate with sticky sat_o.
module neureka_accumulator_buffer_stream
    import neureka_acc_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 32,
    parameter  int unsigned NUM_WORDS     = 32,
    parameter  int unsigned WIDTH_FACTOR  = 8,
    parameter  int unsigned WINDOW_STRIDE = 4,
    localparam int unsigned ADDR_WIDTH    = $clog2(NUM_WORDS),
    localparam int unsigned WIN_WIDTH     = $clog2(NUM_WORDS / WINDOW_STRIDE),
    localparam int unsigned BEATS         = NUM_WORDS / WIDTH_FACTOR
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               enable_i,
    input  logic                               clear_i,
    input  logic                               we_i,
    input  logic [ADDR_WIDTH-1:0]              waddr_i,
    input  logic [DATA_WIDTH-1:0]              wdata_i,
    input  logic                               wide_valid_i,
    output logic                               wide_ready_o,
    input  logic                               wide_acc_i,
    input  logic [WIN_WIDTH-1:0]               wide_win_i,
    input  logic [WIDTH_FACTOR-1:0]            wide_mask_i,
    input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0] wide_data_i,
    input  logic [ADDR_WIDTH-1:0]              raddr_i,
    output logic [DATA_WIDTH-1:0]              rdata_o,
    input  logic [WIN_WIDTH-1:0]               rwin_i,
    output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] rdata_wide_o,
    input  logic                               drain_start_i,
    output logic                               drain_valid_o,
    input  logic                               drain_ready_i,
    output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] drain_data_o,
    output logic                               drain_last_o,
    output logic                               busy_o,
    output logic                               sat_o
);

    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [DATA_WIDTH-1:0] buf_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] buf_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]  touched;
    logic [DATA_WIDTH-1:0] operand;

    acc_wide_req_t     req, s1_q;
    logic              s1_valid_q;
    logic              wide_fire;
    logic              commit;
    logic              fsm_idle;
    logic [BEAT_W-1:0] beat;
    int unsigned       ridx, didx, cidx;
    logic              unused_s1;

    assign wide_ready_o = rst_ni & enable_i & ~clear_i & fsm_idle;
    assign wide_fire    = wide_valid_i & wide_ready_o;
    assign commit       = enable_i & ~clear_i & s1_valid_q;
    assign busy_o       = ~fsm_idle | s1_valid_q;
    assign unused_s1    = ^{s1_q.win, s1_q.mask, s1_q.data};

    always_comb begin
        req      = '0;
        req.win  = ACC_MAX_WIN_W'(wide_win_i);
        req.mask = ACC_MAX_WF'(wide_mask_i);
        req.data = ACC_MAX_DATA_W'(wide_data_i);
        req.acc  = wide_acc_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (enable_i) begin
            s1_valid_q <= wide_fire;
            if (wide_fire) begin
                s1_q <= req;
            end
        end
    end

    // Read ports and drain payload; window words past the end read as zero.
    always_comb begin
        rdata_o      = '0;
        rdata_wide_o = '0;
        drain_data_o = '0;
        ridx         = '0;
        didx         = '0;
        if (32'(raddr_i) < NUM_WORDS) begin
            rdata_o = buf_q[raddr_i];
        end
        for (int unsigned j = 0; j < WIDTH_FACTOR; j++) begin
            ridx = 32'(rwin_i) * WINDOW_STRIDE + j;
            if (ridx < NUM_WORDS) begin
                rdata_wide_o[j*DATA_WIDTH +: DATA_WIDTH] = buf_q[ridx[ADDR_WIDTH-1:0]];
            end
            didx = 32'(beat) * WIDTH_FACTOR + j;
            drain_data_o[j*DATA_WIDTH +: DATA_WIDTH] = buf_q[didx[ADDR_WIDTH-1:0]];
        end
    end

`ifdef NEUREKA_ACC_BUF_SAT_EN
    logic                  sat_hit;
    logic                  sat_q;
    logic [ACC_MAX_DW:0]   sum;
    logic                  unused_sum;

    assign unused_sum = ^sum;
`endif

    // The commit reads buf_q, so back-to-back accumulates need no bypass.
    always_comb begin
        buf_d   = buf_q;
        touched = '0;
        cidx    = '0;
        operand = '0;
`ifdef NEUREKA_ACC_BUF_SAT_EN
        sat_hit = 1'b0;
        sum     = '0;
`endif
        if (commit) begin
            for (int unsigned j = 0; j < WIDTH_FACTOR; j++) begin
                cidx    = 32'(s1_q.win[WIN_WIDTH-1:0]) * WINDOW_STRIDE + j;
                operand = s1_q.data[j*DATA_WIDTH +: DATA_WIDTH];
                if (s1_q.mask[j] && cidx < NUM_WORDS) begin
                    touched[cidx[ADDR_WIDTH-1:0]] = 1'b1;
                    if (!s1_q.acc) begin
                        buf_d[cidx[ADDR_WIDTH-1:0]] = operand;
                    end else begin
`ifdef NEUREKA_ACC_BUF_SAT_EN
                        sum = acc_sat_add(
                            ACC_MAX_DW'(signed'(buf_q[cidx[ADDR_WIDTH-1:0]])),
                            ACC_MAX_DW'(signed'(operand)),
                            DATA_WIDTH);
                        buf_d[cidx[ADDR_WIDTH-1:0]] = sum[DATA_WIDTH-1:0];
                        sat_hit = sat_hit | sum[ACC_MAX_DW];
`else
                        buf_d[cidx[ADDR_WIDTH-1:0]] =
                            buf_q[cidx[ADDR_WIDTH-1:0]] + operand;
`endif
                    end
                end
            end
        end
        if (we_i && 32'(waddr_i) < NUM_WORDS && !touched[waddr_i]) begin
            buf_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (enable_i) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                buf_q[i] <= clear_i ? '0 : buf_d[i];
            end
        end
    end

`ifdef NEUREKA_ACC_BUF_SAT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
        end else if (enable_i) begin
            if (clear_i) begin
                sat_q <= 1'b0;
            end else if (sat_hit) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

    // A request landing in the start cycle still has to commit before beat 0.
    neureka_acc_drain_fsm #(
        .BEATS (BEATS)
    ) u_drain_fsm (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .clear_i  (clear_i),
        .start_i  (drain_start_i),
        .flush_i  (s1_valid_q | wide_fire),
        .ready_i  (drain_ready_i),
        .valid_o  (drain_valid_o),
        .last_o   (drain_last_o),
        .beat_o   (beat),
        .idle_o   (fsm_idle)
    );

endmodule

// File: tb/tb_neureka_accumulator_buffer_stream.sv
// Scoreboard bench for the accumulator buffer: window RMW, write priority, drain, clear, saturation.
// Follows NEUREKA_ACC_BUF_SAT_EN to pick the expected accumulate behaviour.
module tb_neureka_accumulator_buffer_stream;

    localparam int DW    = 32;
    localparam int NW    = 32;
    localparam int WF    = 8;
    localparam int WS    = 4;
    localparam int AW    = 5;
    localparam int WW    = 3;
    localparam int BEATS = 4;
    localparam int WIDE  = WF * DW;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            enable_i = 1'b0;
    logic            clear_i = 1'b0;
    logic            we_i = 1'b0;
    logic [AW-1:0]   waddr_i = '0;
    logic [DW-1:0]   wdata_i = '0;
    logic            wide_valid_i = 1'b0;
    logic            wide_ready_o;
    logic            wide_acc_i = 1'b0;
    logic [WW-1:0]   wide_win_i = '0;
    logic [WF-1:0]   wide_mask_i = '0;
    logic [WIDE-1:0] wide_data_i = '0;
    logic [AW-1:0]   raddr_i = '0;
    logic [DW-1:0]   rdata_o;
    logic [WW-1:0]   rwin_i = '0;
    logic [WIDE-1:0] rdata_wide_o;
    logic            drain_start_i = 1'b0;
    logic            drain_valid_o;
    logic            drain_ready_i = 1'b0;
    logic [WIDE-1:0] drain_data_o;
    logic            drain_last_o;
    logic            busy_o;
    logic            sat_o;

    always #5 clk_i = ~clk_i;

    neureka_accumulator_buffer_stream dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .we_i          (we_i),
        .waddr_i       (waddr_i),
        .wdata_i       (wdata_i),
        .wide_valid_i  (wide_valid_i),
        .wide_ready_o  (wide_ready_o),
        .wide_acc_i    (wide_acc_i),
        .wide_win_i    (wide_win_i),
        .wide_mask_i   (wide_mask_i),
        .wide_data_i   (wide_data_i),
        .raddr_i       (raddr_i),
        .rdata_o       (rdata_o),
        .rwin_i        (rwin_i),
        .rdata_wide_o  (rdata_wide_o),
        .drain_start_i (drain_start_i),
        .drain_valid_o (drain_valid_o),
        .drain_ready_i (drain_ready_i),
        .drain_data_o  (drain_data_o),
        .drain_last_o  (drain_last_o),
        .busy_o        (busy_o),
        .sat_o         (sat_o)
    );

    logic [DW-1:0]   mdl [NW];
    logic [WIDE-1:0] exp_q [$];
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic check(input string tag, input logic [WIDE-1:0] got,
                         input logic [WIDE-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDE-1:0] win_exp(input int w);
        logic [WIDE-1:0] r = '0;
        for (int j = 0; j < WF; j++) begin
            if (w * WS + j < NW) r[j*DW +: DW] = mdl[w*WS+j];
        end
        return r;
    endfunction

    function automatic logic [WIDE-1:0] beat_exp(input int b);
        logic [WIDE-1:0] r = '0;
        for (int j = 0; j < WF; j++) r[j*DW +: DW] = mdl[b*WF+j];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wide(input logic acc, input int w, input logic [WF-1:0] m,
                        input logic [WIDE-1:0] d);
        wide_valid_i = 1'b1;
        wide_acc_i   = acc;
        wide_win_i   = WW'(w);
        wide_mask_i  = m;
        wide_data_i  = d;
        cyc();
        wide_valid_i = 1'b0;
        for (int j = 0; j < WF; j++) begin
            if (m[j] && w * WS + j < NW) begin
                if (acc) mdl[w*WS+j] = mdl[w*WS+j] + d[j*DW +: DW];
                else     mdl[w*WS+j] = d[j*DW +: DW];
            end
        end
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        we_i    = 1'b1;
        waddr_i = AW'(a);
        wdata_i = d;
        cyc();
        we_i    = 1'b0;
        mdl[a]  = d;
    endtask

    task automatic zero_model();
        for (int i = 0; i < NW; i++) mdl[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [WIDE-1:0] d;
        logic            pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int              beats;
        int              k;
        logic            exp_sat;

        zero_model();
        enable_i = 1'b1;
        rwin_i   = 3'd7;
        #3;
        check("rst_ready", WIDE'(wide_ready_o), '0);
        check("rst_outs", WIDE'({busy_o, drain_valid_o, drain_last_o, sat_o}), '0);
        check("rst_win7", rdata_wide_o, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("post_rst_ready", WIDE'(wide_ready_o), WIDE'(1'b1));
        cyc();

        // overwrite window 7: upper four words run past the end
        for (int j = 0; j < WF; j++) d[j*DW +: DW] = DW'(j + 1);
        wide(1'b0, 7, 8'hFF, d);
        raddr_i = AW'(28);
        #1;
        check("ovw_pending", WIDE'(rdata_o), '0);
        cyc();
        raddr_i = AW'(31);
        #1;
        check("ovw_win7", rdata_wide_o, win_exp(7));
        check("ovw_word31", WIDE'(rdata_o), WIDE'(32'd4));

        // three back-to-back accumulates into window 1, low half only
        wr(8, 32'd77);
        for (int j = 0; j < WF; j++) d[j*DW +: DW] = 32'd5;
        wide(1'b1, 1, 8'h0F, d);
        wide(1'b1, 1, 8'h0F, d);
        wide(1'b1, 1, 8'h0F, d);
        raddr_i = AW'(4);
        #1;
        check("acc_pending", WIDE'(rdata_o), WIDE'(32'd10));
        cyc();
        rwin_i  = 3'd1;
        raddr_i = AW'(8);
        #1;
        check("acc_win1", rdata_wide_o, win_exp(1));
        check("acc_word8", WIDE'(rdata_o), WIDE'(32'd77));

        // single write colliding with a commit is dropped
        d = '0;
        d[1*DW +: DW] = 32'd42;
        wide(1'b0, 1, 8'h02, d);
        we_i    = 1'b1;
        waddr_i = AW'(5);
        wdata_i = 32'd99;
        cyc();
        we_i    = 1'b0;
        raddr_i = AW'(5);
        #1;
        check("prio_word5", WIDE'(rdata_o), WIDE'(mdl[5]));
        d[1*DW +: DW] = 32'd43;
        wide(1'b0, 1, 8'h02, d);
        wr(20, 32'd55);
        #1;
        check("prio_word5b", WIDE'(rdata_o), WIDE'(mdl[5]));
        raddr_i = AW'(20);
        #1;
        check("prio_word20", WIDE'(rdata_o), WIDE'(32'd55));

        // enable low freezes everything
        enable_i     = 1'b0;
        wide_valid_i = 1'b1;
        wide_acc_i   = 1'b0;
        wide_win_i   = '0;
        wide_mask_i  = 8'hFF;
        we_i         = 1'b1;
        waddr_i      = '0;
        wdata_i      = 32'd123;
        raddr_i      = '0;
        #1;
        check("dis_ready", WIDE'(wide_ready_o), '0);
        cyc();
        cyc();
        check("dis_word0", WIDE'(rdata_o), WIDE'(mdl[0]));
        check("dis_busy", WIDE'(busy_o), '0);
        wide_valid_i = 1'b0;
        we_i         = 1'b0;
        enable_i     = 1'b1;

        // fill the whole buffer with distinct values
        for (int w = 0; w < 8; w += 2) begin
            for (int j = 0; j < WF; j++) d[j*DW +: DW] = DW'(32'h100 + w * 16 + j);
            wide(1'b0, w, 8'hFF, d);
        end
        cyc();
        cyc();

        // drain with a stalling consumer
        for (int b = 0; b < BEATS; b++) exp_q.push_back(beat_exp(b));
        drain_start_i = 1'b1;
        cyc();
        drain_start_i = 1'b0;
        check("drn_busy", WIDE'(busy_o), WIDE'(1'b1));
        beats = 0;
        k     = 0;
        while (exp_q.size() > 0 && k < 40) begin
            drain_ready_i = (k < 6) ? pat[k] : 1'b1;
            @(negedge clk_i);
            if (drain_valid_o) begin
                check($sformatf("drn_data%0d", beats), drain_data_o, exp_q[0]);
                check($sformatf("drn_last%0d", beats), WIDE'(drain_last_o),
                      WIDE'(beats == BEATS - 1));
                if (drain_ready_i) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            cyc();
            k++;
        end
        drain_ready_i = 1'b0;
        check("drn_beats", WIDE'(beats), WIDE'(BEATS));
        check("drn_idle", WIDE'({drain_valid_o, busy_o}), '0);

        // second drain aborted by clear on beat 2
        drain_start_i = 1'b1;
        cyc();
        drain_start_i = 1'b0;
        drain_ready_i = 1'b1;
        beats = 0;
        k     = 0;
        while (beats < 2 && k < 20) begin
            @(negedge clk_i);
            if (drain_valid_o) begin
                check($sformatf("clr_data%0d", beats), drain_data_o, beat_exp(beats));
                beats++;
            end
            cyc();
            k++;
        end
        check("clr_reach", WIDE'(beats), WIDE'(2));
        check("clr_beat2", drain_data_o, beat_exp(2));
        drain_ready_i = 1'b0;
        clear_i       = 1'b1;
        cyc();
        clear_i = 1'b0;
        zero_model();
        rwin_i  = 3'd4;
        #1;
        check("clr_outs", WIDE'({drain_valid_o, drain_last_o, busy_o}), '0);
        check("clr_ready", WIDE'(wide_ready_o), WIDE'(1'b1));
        check("clr_win4", rdata_wide_o, win_exp(4));
        rwin_i = 3'd0;
        #1;
        check("clr_win0", rdata_wide_o, win_exp(0));

        // overflow on accumulate
        wr(0, 32'h7FFF_FFF0);
        d = '0;
        d[0 +: DW] = 32'h20;
        wide(1'b1, 0, 8'h01, d);
        exp_sat = 1'b0;
`ifdef NEUREKA_ACC_BUF_SAT_EN
        mdl[0]  = 32'h7FFF_FFFF;
        exp_sat = 1'b1;
`endif
        cyc();
        raddr_i = '0;
        #1;
        check("sat_word0", WIDE'(rdata_o), WIDE'(mdl[0]));
        check("sat_flag", WIDE'(sat_o), WIDE'(exp_sat));
        cyc();
        check("sat_hold", WIDE'(sat_o), WIDE'(exp_sat));
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        zero_model();
        #1;
        check("sat_clr", WIDE'(sat_o), '0);
        check("sat_clr_word0", WIDE'(rdata_o), WIDE'(mdl[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
